// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states, pending
// mul/div entry payload and statistics helpers.
package wb_arb_pkg;

  localparam int unsigned STAT_W     = 16;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // Entry widths track the arbiter's default DATA_W/ADDR_W.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } md_entry_t;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] base,
                                                input logic [STAT_W-1:0] inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Compacting register FIFO for pending mul/div results with per-entry kill.
// Kill-count output exists only when WB_ARB_STATS_EN is defined.
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  md_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [ARB_ADDR_W-1:0] kill_addr,
`ifdef WB_ARB_STATS_EN
  output logic [STAT_W-1:0]     kill_cnt_c,
`endif
  output logic                  head_valid,
  output md_entry_t             head,
  output logic                  head_kill_c,
  output logic                  nonempty_nxt_c,
  output logic [CNT_W-1:0]      count
);

  md_entry_t        ent_q [DEPTH];
  md_entry_t        ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] kill_hit;
  logic [CNT_W-1:0] count_d;
  logic             push_kill;
  logic             push_keep;

  // Address match against every stored entry and the incoming one.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      kill_hit[i] = vld_q[i] && kill_en && (ent_q[i].addr == kill_addr);
    end
    push_kill = push && kill_en && (push_entry.addr == kill_addr);
    push_keep = push && !push_kill && (push_entry.addr != '0);
  end

  // Survivors slide toward slot 0, so the head is always slot 0.
  always_comb begin
    count_d = '0;
    vld_d   = '0;
    ent_d   = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !kill_hit[i] && !(pop && (i == 0))) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (count_d == CNT_W'(j)) begin
            ent_d[j] = ent_q[i];
            vld_d[j] = 1'b1;
          end
        end
        count_d = count_d + CNT_W'(1);
      end
    end
    if (push_keep) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (count_d == CNT_W'(j)) begin
          ent_d[j] = push_entry;
          vld_d[j] = 1'b1;
        end
      end
      count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      count <= count_d;
      ent_q <= ent_d;
    end
  end

`ifdef WB_ARB_STATS_EN
  always_comb begin
    kill_cnt_c = STAT_W'(push_kill);
    for (int i = 0; i < DEPTH; i++) begin
      kill_cnt_c = kill_cnt_c + STAT_W'(kill_hit[i]);
    end
  end
`endif

  assign head_valid     = vld_q[0];
  assign head           = ent_q[0];
  assign head_kill_c    = kill_hit[0];
  assign nonempty_nxt_c = vld_d[0];

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between MEM/WB writeback and queued
// mul/div results, stalling the pipeline when the queue head starves.
// Statistics counters are built only when WB_ARB_STATS_EN is defined.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_read_data,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic [ADDR_W-1:0] wb_write_reg_addr,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0] md_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_pipe,
  output logic [STAT_W-1:0] stat_md_writes,
  output logic [STAT_W-1:0] stat_stall_cycles,
  output logic [STAT_W-1:0] stat_kills
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              pipe_active;
  logic              force_c;
  logic              pipe_grant;
  logic              fifo_grant;
  logic              push;
  md_entry_t         push_entry;
  md_entry_t         head;
  logic              head_valid;
  logic              head_kill;
  logic              nonempty_nxt;
  logic [CNT_W-1:0]  fifo_count;
`ifdef WB_ARB_STATS_EN
  logic [STAT_W-1:0] kill_cnt;
`endif

  // Address-0 writes leave the port idle for draining.
  assign pipe_active = wb_reg_write && (wb_write_reg_addr != '0);
  assign force_c     = (state_q == FORCE);
  assign pipe_grant  = pipe_active && !force_c;
  assign fifo_grant  = head_valid && (force_c || !pipe_active);
  assign md_ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push        = md_valid && md_ready;
  assign stall_pipe  = force_c;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = ARB_ADDR_W'(md_addr);
    push_entry.data = ARB_DATA_W'(md_data);
  end

  wb_pend_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_pend_fifo (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_entry     (push_entry),
    .pop            (fifo_grant),
    .kill_en        (pipe_grant),
    .kill_addr      (ARB_ADDR_W'(wb_write_reg_addr)),
`ifdef WB_ARB_STATS_EN
    .kill_cnt_c     (kill_cnt),
`endif
    .head_valid     (head_valid),
    .head           (head),
    .head_kill_c    (head_kill),
    .nonempty_nxt_c (nonempty_nxt),
    .count          (fifo_count)
  );

  // Write-port mux: pipeline first unless a forced head write is in progress.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (pipe_grant) begin
      rf_we    = 1'b1;
      rf_waddr = wb_write_reg_addr;
      rf_wdata = wb_mem_to_reg ? wb_read_data : wb_write_data;
    end else if (fifo_grant) begin
      rf_we    = 1'b1;
      rf_waddr = ADDR_W'(head.addr);
      rf_wdata = DATA_W'(head.data);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Starvation tracking: the counter runs only while the head is blocked.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (nonempty_nxt) state_d = PEND;
      end
      PEND: begin
        if (!nonempty_nxt) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (fifo_grant || head_kill) begin
          wait_d = '0;
        end else if (pipe_active) begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q + WAIT_W'(1) == WAIT_W'(MAX_WAIT)) state_d = FORCE;
        end
      end
      FORCE: begin
        wait_d  = '0;
        state_d = nonempty_nxt ? PEND : IDLE;
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

`ifdef WB_ARB_STATS_EN
  logic [STAT_W-1:0] md_writes_q, stall_cycles_q, kills_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_writes_q    <= '0;
      stall_cycles_q <= '0;
      kills_q        <= '0;
    end else begin
      if (fifo_grant) md_writes_q <= sat_add(md_writes_q, STAT_W'(1));
      if (force_c) stall_cycles_q <= sat_add(stall_cycles_q, STAT_W'(1));
      if (kill_cnt != '0) kills_q <= sat_add(kills_q, kill_cnt);
    end
  end

  assign stat_md_writes    = md_writes_q;
  assign stat_stall_cycles = stall_cycles_q;
  assign stat_kills        = kills_q;
`else
  assign stat_md_writes    = '0;
  assign stat_stall_cycles = '0;
  assign stat_kills        = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: writeback bypass, idle drain, starvation
// stall, WAW kill, full FIFO and reset during a forced stall.
module tb_wb_port_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
`ifdef WB_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_reg_write, wb_mem_to_reg;
  logic [DATA_W-1:0] wb_read_data, wb_write_data;
  logic [ADDR_W-1:0] wb_write_reg_addr;
  logic              md_valid, md_ready;
  logic [DATA_W-1:0] md_data;
  logic [ADDR_W-1:0] md_addr;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_pipe;
  logic [15:0]       stat_md_writes, stat_stall_cycles, stat_kills;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  wb_port_arbiter #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .FIFO_DEPTH (2), .MAX_WAIT (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_reg_write      (wb_reg_write),
    .wb_mem_to_reg     (wb_mem_to_reg),
    .wb_read_data      (wb_read_data),
    .wb_write_data     (wb_write_data),
    .wb_write_reg_addr (wb_write_reg_addr),
    .md_valid          (md_valid),
    .md_ready          (md_ready),
    .md_data           (md_data),
    .md_addr           (md_addr),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .stall_pipe        (stall_pipe),
    .stat_md_writes    (stat_md_writes),
    .stat_stall_cycles (stat_stall_cycles),
    .stat_kills        (stat_kills)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input int unsigned mw, input int unsigned st, input int unsigned kl);
    check("stat_md_writes", 32'(stat_md_writes), STATS_ON ? mw : 32'd0);
    check("stat_stall_cycles", 32'(stat_stall_cycles), STATS_ON ? st : 32'd0);
    check("stat_kills", 32'(stat_kills), STATS_ON ? kl : 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [ADDR_W-1:0] a, input logic m2r,
                          input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] wd);
    wb_reg_write      = we;
    wb_write_reg_addr = a;
    wb_mem_to_reg     = m2r;
    wb_read_data      = rd;
    wb_write_data     = wd;
  endtask

  task automatic set_md(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    md_valid = v;
    md_addr  = a;
    md_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    set_pipe(1'b0, '0, 1'b0, '0, '0);
    set_md(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_stall", 32'(stall_pipe), 32'd0);
    check("rst_md_ready", 32'(md_ready), 32'd1);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check_stats(0, 0, 0);
    tick();
    reset = 1'b0;

    // Pipeline-only writeback, both data sources, then address 0
    set_pipe(1'b1, 5'd5, 1'b1, 32'hAAAA_0000, 32'h5555_5555);
    @(negedge clk);
    check("wb_we", 32'(rf_we), 32'd1);
    check("wb_waddr", 32'(rf_waddr), 32'd5);
    check("wb_wdata_load", rf_wdata, 32'hAAAA_0000);
    wb_mem_to_reg = 1'b0;
    #1;
    check("wb_wdata_alu", rf_wdata, 32'h5555_5555);
    tick();
    set_pipe(1'b1, 5'd0, 1'b0, '0, 32'h1111_1111);
    @(negedge clk);
    check("wb_addr0_we", 32'(rf_we), 32'd0);

    // Idle drain: accepted this cycle, written the next
    tick();
    set_pipe(1'b0, '0, 1'b0, '0, '0);
    set_md(1'b1, 5'd7, 32'h0000_1234);
    @(negedge clk);
    check("drain_same_cycle_we", 32'(rf_we), 32'd0);
    tick();
    set_md(1'b0, '0, '0);
    @(negedge clk);
    check("drain_we", 32'(rf_we), 32'd1);
    check("drain_waddr", 32'(rf_waddr), 32'd7);
    check("drain_wdata", rf_wdata, 32'h0000_1234);
    tick();
    @(negedge clk);
    check("drain_done_we", 32'(rf_we), 32'd0);
    check_stats(1, 0, 0);

    // Starvation: continuous pipeline writes, forced stall 5 cycles after push
    tick();
    set_pipe(1'b1, 5'd3, 1'b0, '0, 32'h0000_0033);
    set_md(1'b1, 5'd10, 32'h0000_BEEF);
    @(negedge clk);
    check("starve_push_stall", 32'(stall_pipe), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      set_md(1'b0, '0, '0);
      @(negedge clk);
      check($sformatf("starve_stall_c%0d", k), 32'(stall_pipe), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("starve_waddr_c%0d", k), 32'(rf_waddr), (k == 5) ? 32'd10 : 32'd3);
      check($sformatf("starve_wdata_c%0d", k), rf_wdata, (k == 5) ? 32'h0000_BEEF : 32'h0000_0033);
    end
    tick();
    set_pipe(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("starve_after_we", 32'(rf_we), 32'd0);
    check_stats(2, 1, 0);

    // WAW kill of a stored entry
    tick();
    set_pipe(1'b1, 5'd4, 1'b0, '0, 32'h0000_4444);
    set_md(1'b1, 5'd9, 32'h0000_9999);
    @(negedge clk);
    tick();
    set_md(1'b0, '0, '0);
    set_pipe(1'b1, 5'd9, 1'b0, '0, 32'h0000_0909);
    @(negedge clk);
    check("waw_waddr", 32'(rf_waddr), 32'd9);
    check("waw_wdata", rf_wdata, 32'h0000_0909);
    tick();
    set_pipe(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("waw_killed_we", 32'(rf_we), 32'd0);

    // WAW kill of an entry accepted in the same cycle
    tick();
    set_pipe(1'b1, 5'd12, 1'b0, '0, 32'h0000_0C0C);
    set_md(1'b1, 5'd12, 32'h0000_DEAD);
    @(negedge clk);
    check("waw_push_wdata", rf_wdata, 32'h0000_0C0C);
    tick();
    set_pipe(1'b0, '0, 1'b0, '0, '0);
    set_md(1'b0, '0, '0);
    @(negedge clk);
    check("waw_push_killed_we", 32'(rf_we), 32'd0);

    // Address-0 mul/div result is swallowed
    tick();
    set_md(1'b1, 5'd0, 32'h0000_F00D);
    @(negedge clk);
    tick();
    set_md(1'b0, '0, '0);
    @(negedge clk);
    check("md_addr0_we", 32'(rf_we), 32'd0);
    check_stats(2, 1, 2);

    // Full FIFO back-pressure under continuous pipeline writes
    tick();
    set_pipe(1'b1, 5'd3, 1'b0, '0, 32'h0000_0033);
    set_md(1'b1, 5'd20, 32'h0000_0020);
    @(negedge clk);
    check("full_rdy0", 32'(md_ready), 32'd1);
    tick();
    set_md(1'b1, 5'd21, 32'h0000_0021);
    @(negedge clk);
    check("full_rdy1", 32'(md_ready), 32'd1);
    tick();
    set_md(1'b1, 5'd22, 32'h0000_0022);
    @(negedge clk);
    check("full_rdy2", 32'(md_ready), 32'd0);
    tick();
    @(negedge clk);
    check("full_rdy3", 32'(md_ready), 32'd0);
    check("full_stall3", 32'(stall_pipe), 32'd0);
    tick();
    set_pipe(1'b0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("full_rdy4", 32'(md_ready), 32'd0);
    check("full_drain0_waddr", 32'(rf_waddr), 32'd20);
    check("full_drain0_wdata", rf_wdata, 32'h0000_0020);
    tick();
    @(negedge clk);
    check("full_rdy5", 32'(md_ready), 32'd1);
    check("full_drain1_waddr", 32'(rf_waddr), 32'd21);
    tick();
    set_md(1'b0, '0, '0);
    @(negedge clk);
    check("full_drain2_waddr", 32'(rf_waddr), 32'd22);
    check("full_drain2_wdata", rf_wdata, 32'h0000_0022);
    tick();
    @(negedge clk);
    check("full_empty_we", 32'(rf_we), 32'd0);
    check_stats(5, 1, 2);

    // Reset while forcing with two entries pending
    tick();
    set_pipe(1'b1, 5'd3, 1'b0, '0, 32'h0000_0033);
    set_md(1'b1, 5'd25, 32'h0000_0025);
    @(negedge clk);
    tick();
    set_md(1'b1, 5'd26, 32'h0000_0026);
    @(negedge clk);
    for (int k = 2; k <= 4; k++) begin
      tick();
      set_md(1'b0, '0, '0);
      @(negedge clk);
      check($sformatf("rstf_stall_c%0d", k), 32'(stall_pipe), 32'd0);
    end
    tick();
    @(negedge clk);
    check("rstf_force_stall", 32'(stall_pipe), 32'd1);
    check("rstf_force_rdy", 32'(md_ready), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check("rstf_async_stall", 32'(stall_pipe), 32'd0);
    check("rstf_async_rdy", 32'(md_ready), 32'd1);
    check_stats(0, 0, 0);
    tick();
    reset = 1'b0;
    set_pipe(1'b0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rstf_no_write_c%0d", k), 32'(rf_we), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
